regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter RegBits, default 32, register data width.
REQ-002 SHALL have parameter AddrBits, default 5, register address width.
REQ-003 SHALL have parameter NumReq, default 2, number of writeback requesters (2..4).
REQ-004 SHALL have port clk_i  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst_i  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port stall_i  input  1  when high, no grants issue.
REQ-007 SHALL have port req_valid_i  input  NumReq  per-requester write request.
REQ-008 SHALL have port req_ready_o  output  NumReq  per-requester grant, one-hot or zero.
REQ-009 SHALL have port req_addr_i  input  NumReq x AddrBits  destination register per requester.
REQ-010 SHALL have port req_data_i  input  NumReq x RegBits  write data per requester.
REQ-011 SHALL have port we3_o  output  1  register file write enable.
REQ-012 SHALL have port a3_o  output  AddrBits  register file write address.
REQ-013 SHALL have port wd3_o  output  RegBits  register file write data.

Function
REQ-014 SHALL complete a transfer on requester i in any cycle where req_valid_i[i] and req_ready_o[i] are both high.
REQ-015 SHALL assert at most one req_ready_o bit per cycle, only to a valid requester, and none while stall_i is high.
REQ-016 SHALL make req_ready_o combinational from req_valid_i, stall_i and the round-robin pointer, never from req_addr_i or req_data_i.
REQ-017 SHALL grant round-robin: search starts at the requester after the last granted one and wraps from NumReq-1 to 0.
REQ-018 SHALL update the pointer only on a completed transfer; a stalled or idle cycle leaves it unchanged.
REQ-019 SHALL guarantee that a continuously valid requester is granted within NumReq cycles when stall_i is low.
REQ-020 SHALL register the granted address and data into an output stage, driving we3_o/a3_o/wd3_o exactly one cycle after the transfer.
REQ-021 SHALL drive we3_o low in any cycle following a cycle with no transfer; a3_o/wd3_o hold their last values.
REQ-022 SHALL accept (assert ready to) a transfer with address 0 but keep we3_o low in the following cycle.
REQ-023 SHALL allow a requester to drop req_valid_i only after its transfer completes; address and data stay stable while valid and not ready.
REQ-024 SHALL sustain back-to-back transfers, one per cycle, with no bubble.

Reset
REQ-025 SHALL, while rst_i is low, force we3_o=0, a3_o=0 and wd3_o=0 immediately and asynchronously.
REQ-026 SHALL reset the pointer so that requester 0 has top priority on the first cycle after reset.
REQ-027 SHALL discard a transfer whose write is pending in the output stage when reset asserts; no write issues after release.

Configuration
REQ-028 SHALL, with macro REGFILE_WB_BYPASS_EN defined, add ports a1_i, a2_i (AddrBits), rd1_i, rd2_i (RegBits), rd1_o, rd2_o (RegBits).
REQ-029 SHALL, with REGFILE_WB_BYPASS_EN defined, drive rdN_o = wd3_o when we3_o is high, a3_o equals aN_i and aN_i is nonzero; otherwise rdN_o = rdN_i, combinationally.
REQ-030 SHALL, without REGFILE_WB_BYPASS_EN, omit those six ports and all forwarding logic.

Structure
REQ-031 SHALL take RegBits/AddrBits defaults and a typedef wb_req_t (addr, data) from shared package rf_pkg.
REQ-032 SHALL implement grant selection in a sub-module rr_arbiter (parameter N; ports req, advance, grant).

Verification
REQ-033 SHALL cover: NumReq=2, req0 valid addr 5 data 0xDEADBEEF -> ready0 same cycle; next cycle we3_o=1, a3_o=5, wd3_o=0xDEADBEEF.
REQ-034 SHALL cover: both valid for 4 cycles straight after reset -> grants 0,1,0,1; we3_o high 4 consecutive cycles.
REQ-035 SHALL cover: req1 valid addr 0 data 0x1234 -> ready1=1; next cycle we3_o=0.
REQ-036 SHALL cover: stall_i=1 for 3 cycles with both valid -> ready=00 each cycle, we3_o=0, pointer unchanged; first grant after stall goes to the requester that had priority before the stall.
REQ-037 SHALL cover: rst_i low in the cycle after a transfer to addr 7 -> we3_o=0 at once; no write to addr 7 after release.
REQ-038 SHALL cover, with REGFILE_WB_BYPASS_EN: output stage writing 0xCAFE to addr 9, a1_i=9, a2_i=3, rd2_i=0x11 -> rd1_o=0xCAFE, rd2_o=0x11.

Source files
------------

// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared register-file widths and writeback request type
package rf_pkg;

  localparam int REG_BITS  = 32;
  localparam int ADDR_BITS = 5;

  typedef struct packed {
    logic [ADDR_BITS-1:0] addr;
    logic [REG_BITS-1:0]  data;
  } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin grant selection; search starts after the last granted requester
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int IdxW = $clog2(N);

  logic [IdxW-1:0] r_last;
  logic [IdxW-1:0] w_sel;
  logic            w_found;
  int              w_j;

  always_comb begin
    grant   = '0;
    w_sel   = r_last;
    w_found = 1'b0;
    w_j     = 0;
    for (int k = 1; k <= N; k++) begin
      w_j = int'(r_last) + k;
      if (w_j >= N) w_j = w_j - N;
      if (!w_found && req[w_j]) begin
        grant[w_j] = 1'b1;
        w_sel      = IdxW'(w_j);
        w_found    = 1'b1;
      end
    end
  end

  // Reset to N-1 so that requester 0 is searched first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= IdxW'(N - 1);
    end else if (advance) begin
      r_last <= w_sel;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin writeback arbiter feeding a registered RF write port
// Optional read-port forwarding enabled by macro REGFILE_WB_BYPASS_EN.
module regfile_wb_arbiter
  import rf_pkg::*;
#(
  parameter int RegBits  = REG_BITS,
  parameter int AddrBits = ADDR_BITS,
  parameter int NumReq   = 2
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               stall_i,
  input  logic [NumReq-1:0]                  req_valid_i,
  output logic [NumReq-1:0]                  req_ready_o,
  input  logic [NumReq-1:0][AddrBits-1:0]    req_addr_i,
  input  logic [NumReq-1:0][RegBits-1:0]     req_data_i,
`ifdef REGFILE_WB_BYPASS_EN
  input  logic [AddrBits-1:0]                a1_i,
  input  logic [AddrBits-1:0]                a2_i,
  input  logic [RegBits-1:0]                 rd1_i,
  input  logic [RegBits-1:0]                 rd2_i,
  output logic [RegBits-1:0]                 rd1_o,
  output logic [RegBits-1:0]                 rd2_o,
`endif
  output logic                               we3_o,
  output logic [AddrBits-1:0]                a3_o,
  output logic [RegBits-1:0]                 wd3_o
);

  logic [NumReq-1:0] w_req;
  logic [NumReq-1:0] w_grant;
  logic              w_xfer;
  wb_req_t           w_sel;

  logic                r_we;
  logic [AddrBits-1:0] r_a3;
  logic [RegBits-1:0]  r_wd3;

  // Grants depend only on valid, stall and the pointer, never on payload.
  assign w_req       = stall_i ? '0 : req_valid_i;
  assign req_ready_o = w_grant;
  assign w_xfer      = |w_grant;

  rr_arbiter #(.N(NumReq)) u_rr (
    .clk     (clk_i),
    .rst_n   (rst_i),
    .req     (w_req),
    .advance (w_xfer),
    .grant   (w_grant)
  );

  always_comb begin
    w_sel = '0;
    for (int i = 0; i < NumReq; i++) begin
      if (w_grant[i]) begin
        w_sel.addr = ADDR_BITS'(req_addr_i[i]);
        w_sel.data = REG_BITS'(req_data_i[i]);
      end
    end
  end

  // Writes to register 0 are accepted but never reach the register file.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_we  <= 1'b0;
      r_a3  <= '0;
      r_wd3 <= '0;
    end else begin
      r_we <= w_xfer && (w_sel.addr != '0);
      if (w_xfer) begin
        r_a3  <= AddrBits'(w_sel.addr);
        r_wd3 <= RegBits'(w_sel.data);
      end
    end
  end

  assign we3_o = r_we;
  assign a3_o  = r_a3;
  assign wd3_o = r_wd3;

`ifdef REGFILE_WB_BYPASS_EN
  logic w_fwd1;
  logic w_fwd2;

  assign w_fwd1 = r_we && (r_a3 == a1_i) && (a1_i != '0);
  assign w_fwd2 = r_we && (r_a3 == a2_i) && (a2_i != '0);
  assign rd1_o  = w_fwd1 ? r_wd3 : rd1_i;
  assign rd2_o  = w_fwd2 ? r_wd3 : rd2_i;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

  logic            clk_i;
  logic            rst_i;
  logic            stall_i;
  logic [1:0]      req_valid_i;
  logic [1:0]      req_ready_o;
  logic [1:0][4:0] req_addr_i;
  logic [1:0][31:0] req_data_i;
  logic            we3_o;
  logic [4:0]      a3_o;
  logic [31:0]     wd3_o;
`ifdef REGFILE_WB_BYPASS_EN
  logic [4:0]      a1_i, a2_i;
  logic [31:0]     rd1_i, rd2_i, rd1_o, rd2_o;
`endif

  int checks = 0;
  int errors = 0;

  regfile_wb_arbiter dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .stall_i     (stall_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_addr_i  (req_addr_i),
    .req_data_i  (req_data_i),
`ifdef REGFILE_WB_BYPASS_EN
    .a1_i        (a1_i),
    .a2_i        (a2_i),
    .rd1_i       (rd1_i),
    .rd2_i       (rd2_i),
    .rd1_o       (rd1_o),
    .rd2_o       (rd2_o),
`endif
    .we3_o       (we3_o),
    .a3_o        (a3_o),
    .wd3_o       (wd3_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [1:0] exp_gnt [4];
    exp_gnt[0] = 2'b01; exp_gnt[1] = 2'b10; exp_gnt[2] = 2'b01; exp_gnt[3] = 2'b10;

    rst_i = 1'b0; stall_i = 1'b0; req_valid_i = '0; req_addr_i = '0; req_data_i = '0;
`ifdef REGFILE_WB_BYPASS_EN
    a1_i = '0; a2_i = '0; rd1_i = '0; rd2_i = '0;
`endif
    repeat (2) @(negedge clk_i);
    #1;
    check("rst_we", 64'(we3_o), 64'd0);
    check("rst_a3", 64'(a3_o), 64'd0);
    check("rst_wd3", 64'(wd3_o), 64'd0);
    check("rst_ready", 64'(req_ready_o), 64'd0);
    @(negedge clk_i);
    rst_i = 1'b1;

    // single transfer on requester 0
    req_valid_i = 2'b01; req_addr_i[0] = 5'd5; req_data_i[0] = 32'hDEADBEEF;
    #1 check("single_ready", 64'(req_ready_o), 64'b01);
    @(negedge clk_i);
    req_valid_i = '0;
    #1;
    check("single_we", 64'(we3_o), 64'd1);
    check("single_a3", 64'(a3_o), 64'd5);
    check("single_wd3", 64'(wd3_o), 64'hDEADBEEF);
    @(negedge clk_i);
    #1;
    check("idle_we", 64'(we3_o), 64'd0);
    check("idle_a3_hold", 64'(a3_o), 64'd5);
    check("idle_wd3_hold", 64'(wd3_o), 64'hDEADBEEF);

    // fresh reset, then both requesters valid for four cycles
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    req_valid_i = 2'b11;
    req_addr_i[0] = 5'd1; req_data_i[0] = 32'h100;
    req_addr_i[1] = 5'd2; req_data_i[1] = 32'h200;
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("rr_grant%0d", k), 64'(req_ready_o), 64'(exp_gnt[k]));
      if (k > 0) begin
        check($sformatf("rr_we%0d", k), 64'(we3_o), 64'd1);
        check($sformatf("rr_a3_%0d", k), 64'(a3_o), (k % 2 == 1) ? 64'd1 : 64'd2);
      end
      @(negedge clk_i);
    end
    req_valid_i = '0;
    #1;
    check("rr_we3", 64'(we3_o), 64'd1);
    check("rr_a3_4", 64'(a3_o), 64'd2);
    check("rr_wd3_4", 64'(wd3_o), 64'h200);

    // address 0 is accepted but not written
    @(negedge clk_i);
    req_valid_i = 2'b10; req_addr_i[1] = 5'd0; req_data_i[1] = 32'h1234;
    #1 check("zero_ready", 64'(req_ready_o), 64'b10);
    @(negedge clk_i);
    req_valid_i = '0;
    #1 check("zero_we", 64'(we3_o), 64'd0);

    // grant requester 0 so requester 1 holds priority across the stall
    @(negedge clk_i);
    req_valid_i = 2'b01; req_addr_i[0] = 5'd3; req_data_i[0] = 32'h33;
    #1 check("pre_stall_ready", 64'(req_ready_o), 64'b01);
    @(negedge clk_i);
    stall_i = 1'b1; req_valid_i = 2'b11; req_addr_i[1] = 5'd4; req_data_i[1] = 32'h44;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("stall_ready%0d", k), 64'(req_ready_o), 64'b00);
      check($sformatf("stall_we%0d", k), 64'(we3_o), (k == 0) ? 64'd1 : 64'd0);
      @(negedge clk_i);
    end
    stall_i = 1'b0;
    #1 check("post_stall_ready", 64'(req_ready_o), 64'b10);
    @(negedge clk_i);
    req_valid_i = '0;
    #1;
    check("post_stall_we", 64'(we3_o), 64'd1);
    check("post_stall_a3", 64'(a3_o), 64'd4);
    check("post_stall_wd3", 64'(wd3_o), 64'h44);

    // reset while a write to addr 7 sits in the output stage
    @(negedge clk_i);
    req_valid_i = 2'b01; req_addr_i[0] = 5'd7; req_data_i[0] = 32'h77;
    #1 check("r7_ready", 64'(req_ready_o), 64'b01);
    @(posedge clk_i);
    #1;
    req_valid_i = '0;
    check("r7_we_pending", 64'(we3_o), 64'd1);
    rst_i = 1'b0;
    #1;
    check("r7_we_async", 64'(we3_o), 64'd0);
    check("r7_a3_async", 64'(a3_o), 64'd0);
    check("r7_wd3_async", 64'(wd3_o), 64'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("r7_after_we%0d", k), 64'(we3_o), 64'd0);
      check($sformatf("r7_after_a3_%0d", k), 64'(a3_o), 64'd0);
      @(negedge clk_i);
    end

`ifdef REGFILE_WB_BYPASS_EN
    req_valid_i = 2'b01; req_addr_i[0] = 5'd9; req_data_i[0] = 32'hCAFE;
    a1_i = 5'd9; a2_i = 5'd3; rd1_i = 32'h55; rd2_i = 32'h11;
    #1 check("byp_idle_rd1", 64'(rd1_o), 64'h55);
    @(negedge clk_i);
    req_valid_i = '0;
    #1;
    check("byp_rd1", 64'(rd1_o), 64'hCAFE);
    check("byp_rd2", 64'(rd2_o), 64'h11);
    @(negedge clk_i);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
